cu_sched: RTL
=============

Name: cu_sched

Overview:
- Timestep scheduler for the SNN compute unit (NUM_PES processing elements sharing one vth).
- Per inference, runs T_STEPS timesteps. Each timestep has three phases:
  - clear (first timestep only)
  - fan-in accumulation from a weight/spike stream
  - threshold compare
- Captures each PE's output spike per timestep into a spike-train register and hands the result downstream via valid/ready.

Parameters:
- NUM_PES, 4, number of PEs driven in lockstep.
- T_STEPS, 8, timesteps per inference.
- MAX_FANIN, 16, maximum accumulate beats per timestep; IDX_W = $clog2(MAX_FANIN+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  inference request; accepted only in IDLE.
- cfg_fanin  in  IDX_W  beats per timestep, sampled on start accept.
- cfg_vth  in  8  threshold, sampled on start accept.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on OUTPUT handshake.
- wt_valid  in  1  stream beat (weights + input spikes) present.
- wt_ready  out  1  scheduler consumes beat; high only in ACCUM.
- t_idx  out  $clog2(T_STEPS)  current timestep, for upstream addressing.
- in_idx  out  IDX_W  current fan-in index.
- pe_clr  out  1  clear PE membranes.
- pe_en  out  1  accumulate enable (= wt_valid & wt_ready).
- pe_mode  out  1  0 accumulate, 1 compare/fire.
- pe_accum_src  out  1  0 weight path, 1 membrane feedback; 1 only in FIRE.
- pe_vth  out  8  registered threshold to PEs.
- pe_spikes  in  NUM_PES  PE spike outputs, valid in CAPTURE.
- spk_train  out  NUM_PES*T_STEPS  bit [p*T_STEPS+t] = spike of PE p at step t.
- out_valid  out  1  spk_train valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset: all outputs 0, state IDLE, spk_train cleared, counters 0. Applies from any state; an in-flight inference is dropped with no done pulse.
- States: IDLE, CLEAR, ACCUM, FIRE, CAPTURE, OUTPUT.
- IDLE:
  - start=1 latches cfg_fanin, cfg_vth (to pe_vth), clears spk_train, then goes to CLEAR.
  - start in any other state is ignored.
- CLEAR: pe_clr=1 for one cycle; t_idx=0, in_idx=0. Next state is ACCUM, or FIRE if the latched fanin=0.
- ACCUM:
  - wt_ready=1.
  - Each cycle with wt_valid=1: pe_en=1, in_idx increments.
  - On the beat where in_idx==fanin-1, in_idx resets to 0 and the state goes to FIRE.
  - wt_valid=0 stalls with no state change.
- FIRE: pe_mode=1, pe_accum_src=1 for one cycle; next state CAPTURE.
- CAPTURE:
  - spk_train[p*T_STEPS+t_idx] <= pe_spikes[p] for all p.
  - If t_idx==T_STEPS-1, go to OUTPUT. Otherwise t_idx++ and go to ACCUM (membranes persist, no clear).
- OUTPUT:
  - out_valid=1 held until out_ready=1. Handshake happens that same cycle, including when out_ready is already high on the first OUTPUT cycle.
  - On the handshake cycle done=1 and the next state is IDLE; spk_train holds its value until the next start.
- Configuration:
  - cfg_fanin > MAX_FANIN saturates to MAX_FANIN.
  - cfg changes while busy have no effect.
- Latency:
  - start high in cycle 0, CLEAR in cycle 1.
  - With no stalls, out_valid first asserts in cycle 2 + T_STEPS*(fanin+2).
  - Example: T_STEPS=8, fanin=4 gives cycle 50.
- wt_valid outside ACCUM is ignored; no beat is consumed.

Optional Feature:
- Macro CU_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[15:0] and perf_stalls[15:0].
  - Both cleared on start accept.
  - perf_cycles counts every busy cycle; perf_stalls counts ACCUM cycles with wt_valid=0.
  - Both saturate at 16'hFFFF and hold after done.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cu_pkg holds:
  - sched_state_e enum (6 states)
  - PE_MODE_ACCUM / PE_MODE_FIRE constants
  - default NUM_PES / T_STEPS / MAX_FANIN
- One natural sub-module: cu_sched_cnt, the nested in_idx/t_idx counter with terminal flags, instantiated once.
- FSM and spike capture stay in cu_sched.

Test Plan:
- Reset mid-ACCUM (t_idx=3): assert rst for 1 cycle -> next cycle busy=0, wt_ready=0, out_valid=0, spk_train=0, no done.
- fanin=4, wt_valid always 1, out_ready=1, pe_spikes driven 4'b1010 in every CAPTURE:
  - out_valid and done both in cycle 50 after start.
  - spk_train = 8'hFF in PE1 and PE3 fields, 0 in PE0 and PE2 fields.
- fanin=3, wt_valid toggles 1/0 each cycle:
  - exactly 3 pe_en pulses per timestep, 24 total.
  - out_valid in cycle 2+8*(6+2)=66.
- fanin=0: CLEAR -> FIRE directly; zero pe_en pulses; out_valid in cycle 18.
- Backpressure: out_ready=0 for 5 cycles in OUTPUT -> out_valid held, spk_train stable, done only on the out_ready=1 cycle.
- start pulsed while busy, and cfg_fanin=20 with MAX_FANIN=16 -> inference unaffected; accumulation uses 16 beats.
- With CU_SCHED_PERF_EN, the toggle case (fanin=3) yields perf_stalls=24 (one idle cycle per pair of beats).

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and defaults for the SNN compute-unit timestep scheduler.
//   sched_state_e  : scheduler FSM states
//   PE_MODE_*      : encoding of the pe_mode output
//   CU_*           : default NUM_PES / T_STEPS / MAX_FANIN
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_FIRE    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUTPUT  = 3'd5
  } sched_state_e;

  localparam logic PE_MODE_ACCUM = 1'b0;
  localparam logic PE_MODE_FIRE  = 1'b1;

  localparam int CU_NUM_PES   = 4;
  localparam int CU_T_STEPS   = 8;
  localparam int CU_MAX_FANIN = 16;

endpackage

// File: rtl/cu_sched_cnt.sv
// cu_sched_cnt: nested fan-in / timestep counter for cu_sched.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero both counters (start of an inference)
//   beat       : one accumulate beat consumed this cycle
//   step       : advance to the next timestep
//   fanin      : latched beats per timestep
//   in_idx     : current fan-in index
//   t_idx      : current timestep
//   in_last    : in_idx is the last beat of this timestep
//   t_last     : t_idx is the last timestep
module cu_sched_cnt #(
  parameter int T_STEPS = 8,
  parameter int IDX_W   = 5,
  parameter int T_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             beat,
  input  logic             step,
  input  logic [IDX_W-1:0] fanin,
  output logic [IDX_W-1:0] in_idx,
  output logic [T_W-1:0]   t_idx,
  output logic             in_last,
  output logic             t_last
);

  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic [T_W-1:0]   t_idx_q, t_idx_d;

  // fanin is never 0 while beats arrive, so the wrap of fanin-1 is harmless.
  assign in_last = (in_idx_q == (fanin - IDX_W'(1)));
  assign t_last  = (t_idx_q == T_W'(T_STEPS - 1));
  assign in_idx  = in_idx_q;
  assign t_idx   = t_idx_q;

  always_comb begin
    in_idx_d = in_idx_q;
    t_idx_d  = t_idx_q;
    if (clr) begin
      in_idx_d = '0;
      t_idx_d  = '0;
    end else begin
      if (beat) begin
        in_idx_d = in_last ? '0 : in_idx_q + IDX_W'(1);
      end
      if (step) begin
        t_idx_d = t_idx_q + T_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q <= '0;
      t_idx_q  <= '0;
    end else begin
      in_idx_q <= in_idx_d;
      t_idx_q  <= t_idx_d;
    end
  end

endmodule

// File: rtl/cu_sched.sv
// cu_sched: timestep scheduler for the SNN compute unit.
// Each inference runs T_STEPS timesteps; every timestep accumulates fanin
// beats from the weight/spike stream, fires all PEs against a shared vth
// and captures their spikes into spk_train, which is then offered downstream.
// Optional build macro CU_SCHED_PERF_EN adds perf_cycles / perf_stalls.
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high; valid never depends on ready. Stream side: wt_valid/wt_ready (beat
// consumed => pe_en). Output side: out_valid/out_ready (transfer => done).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, cfg_fanin,   : inference request + config, sampled in IDLE only
//   cfg_vth
//   busy, done          : not-IDLE flag, one-cycle output-handshake pulse
//   wt_valid, wt_ready  : weight/spike stream handshake
//   t_idx, in_idx       : timestep and fan-in index for upstream addressing
//   pe_clr, pe_en,      : PE control (clear, accumulate, mode, feedback src)
//   pe_mode, pe_accum_src
//   pe_vth              : latched threshold
//   pe_spikes           : PE spike outputs, sampled in CAPTURE
//   spk_train           : bit [p*T_STEPS+t] = spike of PE p at step t
//   out_valid, out_ready: result handshake
//   dbg_state           : current FSM state
//   perf_cycles, perf_stalls (CU_SCHED_PERF_EN only)
module cu_sched import cu_pkg::*; #(
  parameter int NUM_PES   = CU_NUM_PES,
  parameter int T_STEPS   = CU_T_STEPS,
  parameter int MAX_FANIN = CU_MAX_FANIN,
  localparam int IDX_W    = $clog2(MAX_FANIN + 1),
  localparam int T_W      = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IDX_W-1:0]           cfg_fanin,
  input  logic [7:0]                 cfg_vth,
  output logic                       busy,
  output logic                       done,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  output logic [T_W-1:0]             t_idx,
  output logic [IDX_W-1:0]           in_idx,
  output logic                       pe_clr,
  output logic                       pe_en,
  output logic                       pe_mode,
  output logic                       pe_accum_src,
  output logic [7:0]                 pe_vth,
  input  logic [NUM_PES-1:0]         pe_spikes,
  output logic [NUM_PES*T_STEPS-1:0] spk_train,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 dbg_state
`ifdef CU_SCHED_PERF_EN
  ,
  output logic [15:0]                perf_cycles,
  output logic [15:0]                perf_stalls
`endif
);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0]           fanin_q, fanin_d;
  logic [7:0]                 vth_q, vth_d;
  logic [NUM_PES*T_STEPS-1:0] spk_q, spk_d;

  logic start_acc;
  logic step_adv;
  logic capture;
  logic in_last;
  logic t_last;
  logic fanin_zero;

  cu_sched_cnt #(
    .T_STEPS (T_STEPS),
    .IDX_W   (IDX_W),
    .T_W     (T_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .beat    (pe_en),
    .step    (step_adv),
    .fanin   (fanin_q),
    .in_idx  (in_idx),
    .t_idx   (t_idx),
    .in_last (in_last),
    .t_last  (t_last)
  );

  assign fanin_zero = (fanin_q == '0);

  // Output decode is purely a function of state so IDLE (and reset) drives 0.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    wt_ready     = (state_q == ST_ACCUM);
    pe_en        = wt_valid & wt_ready;
    pe_clr       = (state_q == ST_CLEAR);
    pe_mode      = (state_q == ST_FIRE) ? PE_MODE_FIRE : PE_MODE_ACCUM;
    pe_accum_src = (state_q == ST_FIRE);
    out_valid    = (state_q == ST_OUTPUT);
    done         = out_valid & out_ready;
    capture      = (state_q == ST_CAPTURE);
    pe_vth       = vth_q;
    spk_train    = spk_q;
    dbg_state    = state_q;
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    step_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = fanin_zero ? ST_FIRE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (wt_valid && in_last) begin
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (t_last) begin
          state_d = ST_OUTPUT;
        end else begin
          // Membranes persist across timesteps, so no trip through CLEAR.
          step_adv = 1'b1;
          state_d  = fanin_zero ? ST_FIRE : ST_ACCUM;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config latch and spike-train capture.
  always_comb begin
    fanin_d = fanin_q;
    vth_d   = vth_q;
    spk_d   = spk_q;
    if (start_acc) begin
      fanin_d = (cfg_fanin > IDX_W'(MAX_FANIN)) ? IDX_W'(MAX_FANIN) : cfg_fanin;
      vth_d   = cfg_vth;
      spk_d   = '0;
    end else if (capture) begin
      for (int p = 0; p < NUM_PES; p++) begin
        for (int t = 0; t < T_STEPS; t++) begin
          if (t_idx == T_W'(t)) begin
            spk_d[p*T_STEPS + t] = pe_spikes[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fanin_q <= '0;
      vth_q   <= '0;
      spk_q   <= '0;
    end else begin
      state_q <= state_d;
      fanin_q <= fanin_d;
      vth_q   <= vth_d;
      spk_q   <= spk_d;
    end
  end

`ifdef CU_SCHED_PERF_EN
  logic [15:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  // Both counters saturate and keep their value in IDLE until the next start.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy && (perf_cycles_q != 16'hFFFF)) begin
        perf_cycles_d = perf_cycles_q + 16'd1;
      end
      if (wt_ready && !wt_valid && (perf_stalls_q != 16'hFFFF)) begin
        perf_stalls_d = perf_stalls_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
